// File: rtl/mul_booth_seq_if.sv
// Handshake and operand bundle for the sequential Booth multiplier.
// The master issues start with operands; the slave returns busy/done/M.
interface mul_booth_seq_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic                 signed_mode;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   M;

    modport master (
        output start, signed_mode, A, B,
        input  busy, done, M
    );

    modport slave (
        input  start, signed_mode, A, B,
        output busy, done, M
    );
endinterface

// File: rtl/mul_booth_seq.sv
// Sequential radix-2 Booth multiplier, one Booth step per clock.
// Operands are widened by one bit so one datapath serves both modes.
module mul_booth_seq #(
    parameter int WIDTH = 8
) (
    input logic           clk,
    input logic           rst_n,
    mul_booth_seq_if.slave bus
);
    localparam int XW = WIDTH + 1;
    localparam int CW = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_n;

    logic [XW-1:0]        aext;
    logic [XW-1:0]        p;
    logic [XW-1:0]        q;
    logic                 e;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   m;

    logic [XW-1:0]        sum;
    logic [XW-1:0]        p_n;
    logic [XW-1:0]        q_n;
    logic                 e_n;
    logic [2*WIDTH-1:0]   m_n;
    logic                 accept;
    logic                 last;

    // A new operation is taken whenever no multiply is in progress.
    assign accept = bus.start && (state != RUN);
    assign last   = (cnt == CW'(1));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic; DONE may re-enter RUN for back-to-back issue.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = bus.start ? RUN : IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // One Booth step: conditional add/subtract, then arithmetic shift.
    always_comb begin
        sum = p;
        unique case ({q[0], e})
            2'b10:   sum = p - aext;
            2'b01:   sum = p + aext;
            default: sum = p;
        endcase
        p_n = {sum[XW-1], sum[XW-1:1]};
        q_n = {sum[0], q[XW-1:1]};
        e_n = q[0];
        m_n = {p_n[WIDTH-2:0], q_n};
    end

    // Operand capture, iteration registers and the product register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            aext <= '0;
            p    <= '0;
            q    <= '0;
            e    <= 1'b0;
            cnt  <= '0;
            m    <= '0;
        end else if (accept) begin
            aext <= {bus.signed_mode & bus.A[WIDTH-1], bus.A};
            q    <= {bus.signed_mode & bus.B[WIDTH-1], bus.B};
            p    <= '0;
            e    <= 1'b0;
            cnt  <= CW'(WIDTH + 1);
        end else if (state == RUN) begin
            p   <= p_n;
            q   <= q_n;
            e   <= e_n;
            cnt <= cnt - CW'(1);
            if (last) begin
                m <= m_n;
            end
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.M    = m;
endmodule

// File: tb/tb_mul_booth_seq.sv
// Self-checking bench for mul_booth_seq at WIDTH=8 and WIDTH=4.
// Expected products come from plain integer multiplication.
module tb_mul_booth_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mul_booth_seq_if #(.WIDTH(8)) i8 ();
    mul_booth_seq_if #(.WIDTH(4)) i4 ();

    mul_booth_seq #(.WIDTH(8)) u8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (i8)
    );

    mul_booth_seq #(.WIDTH(4)) u4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (i4)
    );

    typedef struct {
        bit          sm;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] m;
    } vec_t;

    vec_t tbl[10];

    function automatic logic [15:0] ref_mul(int w, bit sm, int a, int b);
        longint xa;
        longint xb;
        longint pr;
        longint mask;
        xa = longint'(a);
        xb = longint'(b);
        if (sm && xa >= (longint'(1) << (w - 1))) xa -= (longint'(1) << w);
        if (sm && xb >= (longint'(1) << (w - 1))) xb -= (longint'(1) << w);
        pr = xa * xb;
        mask = (longint'(1) << (2 * w)) - 1;
        return 16'(pr & mask);
    endfunction

    task automatic chk(input string name, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // One WIDTH=8 operation; optionally scramble inputs and re-pulse start mid-run.
    task automatic op8(input bit sm, input logic [7:0] a, input logic [7:0] b,
                       input bit scramble,
                       output logic [15:0] got, output int lat, output int nb);
        lat = -1;
        nb = 0;
        @(negedge clk);
        i8.start = 1'b1;
        i8.signed_mode = sm;
        i8.A = a;
        i8.B = b;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 1) i8.start = 1'b0;
            if (scramble && c == 3) begin
                i8.A = ~a;
                i8.B = b + 8'd3;
                i8.signed_mode = ~sm;
                i8.start = 1'b1;
            end
            if (scramble && c == 4) i8.start = 1'b0;
            if (i8.busy && i8.done) chk("busy_done_overlap", 1, 0);
            if (i8.done) begin
                lat = c - 1;
                break;
            end
            if (i8.busy) nb++;
        end
        got = i8.M;
        if (lat < 0) chk("timeout8", 0, 1);
    endtask

    initial begin
        logic [15:0] got;
        logic [15:0] exp;
        int lat;
        int nb;
        int waited;
        int seen;
        bit sm;
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] idx;

        tbl[0] = '{1'b1, 8'hFD, 8'h05, 16'hFFF1};
        tbl[1] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
        tbl[2] = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
        tbl[3] = '{1'b1, 8'h80, 8'h80, 16'h4000};
        tbl[4] = '{1'b1, 8'h80, 8'h7F, 16'hC080};
        tbl[5] = '{1'b0, 8'h80, 8'h7F, 16'h3F80};
        tbl[6] = '{1'b1, 8'h7F, 8'h7F, 16'h3F01};
        tbl[7] = '{1'b0, 8'h01, 8'hFF, 16'h00FF};
        tbl[8] = '{1'b1, 8'h01, 8'hFF, 16'hFFFF};
        tbl[9] = '{1'b0, 8'h00, 8'hA5, 16'h0000};

        i8.start = 1'b0; i8.signed_mode = 1'b0; i8.A = '0; i8.B = '0;
        i4.start = 1'b0; i4.signed_mode = 1'b0; i4.A = '0; i4.B = '0;

        repeat (3) @(negedge clk);
        chk("rst_busy8", i8.busy, 0);
        chk("rst_done8", i8.done, 0);
        chk("rst_m8", i8.M, 0);
        chk("rst_m4", i4.M, 0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            op8(tbl[i].sm, tbl[i].a, tbl[i].b, 1'b0, got, lat, nb);
            chk($sformatf("tbl%0d_m", i), got, tbl[i].m);
            chk($sformatf("tbl%0d_lat", i), lat, 9);
            chk($sformatf("tbl%0d_busy", i), nb, 9);
            repeat (2) @(negedge clk);
            chk($sformatf("tbl%0d_hold", i), i8.M, tbl[i].m);
            chk($sformatf("tbl%0d_idle", i), {i8.busy, i8.done}, 0);
        end

        for (int i = 0; i < 40; i++) begin
            sm = 1'($urandom_range(0, 1));
            a = 8'($urandom);
            b = 8'($urandom);
            op8(sm, a, b, 1'b0, got, lat, nb);
            chk($sformatf("rnd%0d", i), got, ref_mul(8, sm, int'(a), int'(b)));
        end

        op8(1'b1, 8'hE7, 8'h35, 1'b1, got, lat, nb);
        chk("scramble_m", got, ref_mul(8, 1'b1, 'hE7, 'h35));
        chk("scramble_lat", lat, 9);
        @(negedge clk);
        chk("scramble_no_restart", i8.busy, 0);

        @(negedge clk);
        i8.start = 1'b1;
        i8.signed_mode = 1'b0;
        i8.A = 8'h33;
        i8.B = 8'h44;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 1) i8.start = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", i8.busy, 0);
        chk("midrst_done", i8.done, 0);
        chk("midrst_m", i8.M, 0);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (i8.done || i8.busy) seen++;
        end
        chk("midrst_quiet", seen, 0);

        idx = '0;
        @(negedge clk);
        i4.start = 1'b1;
        i4.signed_mode = idx[8];
        i4.A = idx[7:4];
        i4.B = idx[3:0];
        for (int n = 0; n < 512; n++) begin
            idx = 9'(n);
            waited = 0;
            do begin
                @(negedge clk);
                waited++;
            end while (!i4.done && waited < 12);
            if (!i4.done) begin
                chk("timeout4", 0, 1);
                break;
            end
            exp = ref_mul(4, idx[8], int'(idx[7:4]), int'(idx[3:0]));
            chk($sformatf("w4_%0d", n), i4.M, exp);
            if (waited != 6) chk($sformatf("w4_gap_%0d", n), waited, 6);
            if (n < 511) begin
                idx = 9'(n + 1);
                i4.signed_mode = idx[8];
                i4.A = idx[7:4];
                i4.B = idx[3:0];
            end else begin
                i4.start = 1'b0;
            end
        end
        repeat (2) @(negedge clk);
        chk("w4_final_idle", {i4.busy, i4.done}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
